// File: rtl/udma_eth_tx_sched.sv
// udma_eth_tx_sched
//
// Queues Ethernet frame descriptors (L2 start address + byte size) and launches
// them one at a time towards the uDMA tx controller. Frame completion is taken
// from the monitored tx AXIS stream (tvalid & tready & tlast). After each frame
// a programmable inter-frame gap is inserted before the next launch.
//
// Ports
//   clk_i, rstn_i                 clock, asynchronous active-low reset
//   desc_valid_i / desc_ready_o   descriptor push handshake
//   desc_addr_i, desc_size_i      descriptor payload (size 0 is dropped)
//   cfg_ifg_i                     inter-frame gap in clk_i cycles
//   clr_i                         flush the descriptor queue
//   tx_startaddr_o, tx_size_o     launched descriptor, held until next launch
//   tx_en_o                       one-cycle launch pulse
//   axis_tvalid_i/tready_i/tlast_i  monitored tx AXIS beat
//   pending_o, empty_o, full_o    queue occupancy
//   busy_o                        launch/run/gap in progress
//   done_evt_o, err_evt_o         frame-done and zero-size-drop pulses

module udma_eth_tx_sched #(
   parameter int unsigned L2_AWIDTH_NOAL = 12,
   parameter int unsigned TRANS_SIZE     = 16,
   parameter int unsigned DEPTH          = 4,
   localparam int unsigned CW            = $clog2(DEPTH + 1)
) (
   input  logic                      clk_i,
   input  logic                      rstn_i,

   input  logic                      desc_valid_i,
   output logic                      desc_ready_o,
   input  logic [L2_AWIDTH_NOAL-1:0] desc_addr_i,
   input  logic [TRANS_SIZE-1:0]     desc_size_i,

   input  logic [7:0]                cfg_ifg_i,
   input  logic                      clr_i,

   output logic [L2_AWIDTH_NOAL-1:0] tx_startaddr_o,
   output logic [TRANS_SIZE-1:0]     tx_size_o,
   output logic                      tx_en_o,

   input  logic                      axis_tvalid_i,
   input  logic                      axis_tready_i,
   input  logic                      axis_tlast_i,

   output logic [CW-1:0]             pending_o,
   output logic                      empty_o,
   output logic                      full_o,
   output logic                      busy_o,
   output logic                      done_evt_o,
   output logic                      err_evt_o
);

   localparam int unsigned PW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      StIdle,
      StLaunch,
      StRun,
      StGap
   } state_e;

   state_e state_q, state_d;

   // Descriptor storage; contents need no reset, validity is tracked by count_q.
   logic [L2_AWIDTH_NOAL-1:0] addr_mem [DEPTH];
   logic [TRANS_SIZE-1:0]     size_mem [DEPTH];

   logic [PW-1:0]             wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]             count_q;
   logic [7:0]                gap_cnt_q, gap_cnt_d;
   logic [L2_AWIDTH_NOAL-1:0] tx_addr_q;
   logic [TRANS_SIZE-1:0]     tx_size_q;
   logic                      done_q, done_d;
   logic                      err_q;

   logic full, empty;
   logic handshake, push, pop, zero_drop;
   logic frame_end, load_head;

   // ---------------------------------------------------------------------------
   // Queue
   // ---------------------------------------------------------------------------
   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);

   assign handshake = desc_valid_i & ~full;
   assign zero_drop = handshake & (desc_size_i == '0);
   // A flush in the same cycle discards the incoming descriptor.
   assign push      = handshake & (desc_size_i != '0) & ~clr_i;
   assign pop       = (state_q == StLaunch) & ~empty;

   always_ff @(posedge clk_i) begin
      if (push) begin
         addr_mem[wr_ptr_q] <= desc_addr_i;
         size_mem[wr_ptr_q] <= desc_size_i;
      end
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (clr_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_q + CW'(push) - CW'(pop);
      end
   end

   // ---------------------------------------------------------------------------
   // Launch / run / gap sequencer
   // ---------------------------------------------------------------------------
   assign frame_end = axis_tvalid_i & axis_tready_i & axis_tlast_i;

   always_comb begin
      state_d   = state_q;
      gap_cnt_d = gap_cnt_q;
      load_head = 1'b0;
      done_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            // A pending flush must not launch the entry it is about to remove.
            if (!empty && !clr_i) begin
               load_head = 1'b1;
               state_d   = StLaunch;
            end
         end
         StLaunch: begin
            state_d = StRun;
         end
         StRun: begin
            if (frame_end) begin
               done_d = 1'b1;
               if (cfg_ifg_i == 8'd0) begin
                  state_d = StIdle;
               end else begin
                  state_d   = StGap;
                  gap_cnt_d = cfg_ifg_i;
               end
            end
         end
         StGap: begin
            if (gap_cnt_q <= 8'd1) begin
               gap_cnt_d = 8'd0;
               state_d   = StIdle;
            end else begin
               gap_cnt_d = gap_cnt_q - 8'd1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q   <= StIdle;
         gap_cnt_q <= 8'd0;
         tx_addr_q <= '0;
         tx_size_q <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         gap_cnt_q <= gap_cnt_d;
         if (load_head) begin
            tx_addr_q <= addr_mem[rd_ptr_q];
            tx_size_q <= size_mem[rd_ptr_q];
         end
         done_q <= done_d;
         err_q  <= zero_drop;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign desc_ready_o   = ~full;
   assign pending_o      = count_q;
   assign empty_o        = empty;
   assign full_o         = full;
   assign tx_startaddr_o = tx_addr_q;
   assign tx_size_o      = tx_size_q;
   assign tx_en_o        = (state_q == StLaunch);
   assign busy_o         = (state_q != StIdle);
   assign done_evt_o     = done_q;
   assign err_evt_o      = err_q;

endmodule

// File: doc/udma_eth_tx_sched.md
UDMA_ETH_TX_SCHED -- requirements
Module: udma_eth_tx_sched

Interface
REQ-001 SHALL have parameter L2_AWIDTH_NOAL, default 12: width of the L2 start address.
REQ-002 SHALL have parameter TRANS_SIZE, default 16: width of the frame byte size.
REQ-003 SHALL have parameter DEPTH, default 4 (power of 2, >=2): number of descriptor queue entries; CW = clog2(DEPTH+1).
REQ-004 clk_i  in  1  single clock; all logic is on its rising edge.
REQ-005 rstn_i  in  1  reset, asynchronous, active-low.
REQ-006 desc_valid_i  in  1  a frame descriptor is offered.
REQ-007 desc_ready_o  out  1  the queue accepts a descriptor.
REQ-008 desc_addr_i  in  L2_AWIDTH_NOAL  frame start address.
REQ-009 desc_size_i  in  TRANS_SIZE  frame length in bytes.
REQ-010 cfg_ifg_i  in  8  inter-frame gap, in clk_i cycles.
REQ-011 clr_i  in  1  flushes the queue.
REQ-012 tx_startaddr_o  out  L2_AWIDTH_NOAL  start address to the tx controller.
REQ-013 tx_size_o  out  TRANS_SIZE  size to the tx controller.
REQ-014 tx_en_o  out  1  single-cycle launch pulse to the tx controller.
REQ-015 axis_tvalid_i, axis_tready_i, axis_tlast_i  in  1 each  monitored tx AXIS beat; frame end = all three high.
REQ-016 pending_o  out  CW  number of queued descriptors.
REQ-017 empty_o / full_o  out  1 each  queue empty / queue full.
REQ-018 busy_o  out  1  a frame is launched and not yet complete, or the gap is running.
REQ-019 done_evt_o  out  1  one-cycle pulse per completed frame.
REQ-020 err_evt_o  out  1  one-cycle pulse when a zero-size descriptor is dropped.

Function
REQ-021 desc_ready_o SHALL equal !full_o; a push SHALL occur only when desc_valid_i && desc_ready_o are both high.
REQ-022 A push with desc_size_i==0 SHALL complete the handshake but SHALL NOT be stored, and err_evt_o SHALL be high in the next cycle.
REQ-023 The queue SHALL be a FIFO of DEPTH entries with wrapping read and write pointers; a push and a pop in the same cycle SHALL leave pending_o unchanged.
REQ-024 The block SHALL have the states IDLE, LAUNCH, RUN and GAP.
REQ-025 IDLE: when !empty_o, the block SHALL register the head entry into tx_startaddr_o/tx_size_o and go to LAUNCH.
REQ-026 LAUNCH: tx_en_o SHALL be 1 for exactly this cycle, the head entry SHALL be popped, and the next state SHALL be RUN.
REQ-027 RUN: on a frame-end beat, done_evt_o SHALL pulse in the next cycle; the next state SHALL be IDLE if cfg_ifg_i==0, otherwise GAP with gap counter = cfg_ifg_i.
REQ-028 GAP: the counter SHALL decrement each cycle and the block SHALL return to IDLE in the cycle it reads 1, giving exactly cfg_ifg_i GAP cycles.
REQ-029 Latency: a push at edge N into an empty queue while in IDLE SHALL give tx_en_o=1 in the cycle after edge N+1.
REQ-030 tx_startaddr_o/tx_size_o SHALL hold stable from LAUNCH until the next LAUNCH.
REQ-031 busy_o SHALL be 1 in LAUNCH, RUN and GAP, and 0 in IDLE.
REQ-032 AXIS beats outside RUN SHALL be ignored.
REQ-033 clr_i SHALL empty the queue at the next edge (pointers and count reset to 0) and SHALL NOT affect the state machine; an in-flight frame and its gap SHALL complete normally.
REQ-034 On clr_i together with a push, clr_i SHALL win and the pushed descriptor SHALL be discarded.
REQ-035 On clr_i in IDLE, no launch SHALL occur from the flushed contents.
REQ-036 cfg_ifg_i SHALL be sampled only on the RUN->GAP transition.

Reset
REQ-037 On rstn_i low, state SHALL be IDLE, and pointers, pending_o, the gap counter, tx_startaddr_o, tx_size_o, tx_en_o, done_evt_o and err_evt_o SHALL all be 0.
REQ-038 On rstn_i low, empty_o SHALL be 1, and full_o and busy_o SHALL be 0.
REQ-039 Reset mid-frame SHALL abandon the frame with no done_evt_o.

Verification
REQ-040 Single frame, ifg=0: push (0x100, 64) into an empty queue -> tx_en_o pulses exactly once 2 cycles later with 0x100/64; frame-end beat -> done_evt_o next cycle, busy_o 0.
REQ-041 Fill: push 4 descriptors while one frame is stalled in RUN -> after the first pops, full_o=1, desc_ready_o=0, and a 5th push is held; the first frame ends -> order is preserved and the held descriptor is accepted after the next pop.
REQ-042 Gap: ifg=5, two queued frames -> exactly 5 GAP cycles after the first frame end before the second LAUNCH, with busy_o held 1 throughout.
REQ-043 Zero size: push size 0 -> err_evt_o pulses once, pending_o stays 0, no tx_en_o.
REQ-044 clr_i: clr_i in RUN with 3 pending -> pending_o=0 next cycle, the current frame still gives done_evt_o, and there is no further LAUNCH.
REQ-045 Reset mid-RUN with 2 pending -> all outputs at reset values, and no launch after release until a new push.
